instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of the control unit.
- Holds the PC, issues one word read per instruction to instruction memory, and captures the returned word in an instruction register.
- Presents the decoded fields (cond, op, funct, rd) to control with a valid/accept handshake.
- Computes the next PC from control's pc_src and the datapath result. Also supplies PC+8 (R15 read value) to the datapath.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  read address; equals pc while imem_req=1
- imem_ready  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instruction register holds an unconsumed instruction
- instr_accept  input  1  control/datapath consume the current instruction this cycle
- pc_src  input  1  from control: take branch/result target (sampled only on accept)
- result  input  ADDR_W  next-PC target from datapath when pc_src=1
- instr  output  32  instruction register
- cond  output  4  instr[31:28]
- op  output  2  instr[27:26]
- funct  output  6  instr[25:20]
- rd  output  4  instr[15:12]
- pc  output  ADDR_W  address of the current instruction
- pc_plus8  output  ADDR_W  pc + 8, modulo 2^ADDR_W
- align_err  output  1  one-cycle pulse: misaligned target taken

Behaviour:
- Reset values (on the clk edge with reset=1): pc=RESET_PC; instr=32'h0; state=FETCH; instr_valid=0; align_err=0. imem_req is 1 from the first cycle after reset deasserts.
- Reset mid-operation: state returns to FETCH and the instruction register is cleared. A response arriving in the same cycle as reset is discarded.
- State FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - If imem_ready=1: instr<=imem_rdata, next state ISSUE.
  - Otherwise remain in FETCH. Wait states are unbounded.
- State ISSUE:
  - imem_req=0, instr_valid=1. instr and fields are stable.
  - imem_ready is ignored; stray responses are dropped.
  - If instr_accept=1:
    - pc <= pc_src ? {result[ADDR_W-1:2],2'b00} : pc+4.
    - Next state FETCH.
  - If instr_accept=0: hold everything.
- instr_accept while in FETCH is ignored (pc unchanged).
- Latency and throughput:
  - Zero-wait memory gives FETCH→ISSUE in 1 cycle.
  - Minimum 2 cycles per instruction.
  - New pc is visible on imem_addr the cycle after accept.
- Arithmetic: pc+4 and pc+8 wrap modulo 2^ADDR_W; no overflow flag.
- Alignment: when an accept has pc_src=1 and result[1:0]≠0, the low bits are forced to 0 and align_err pulses high for the following cycle only.
- Fields are combinational slices of the instruction register, never of imem_rdata.
- pc_plus8 is combinational from the pc register.

Decomposition:
- Shared package holds:
  - the fetch-state enum {FETCH, ISSUE};
  - field position constants (COND_MSB=31, OP_MSB=27, FUNCT_MSB=25, RD_MSB=15);
  - the PC increment constants 4 and 8.
- One natural sub-module, pc_next: combinational next-PC mux/adder plus the alignment check. The top level holds the FSM, the PC and instruction registers, and the field slicing.

Test Plan:
- Reset, then zero-wait memory returning 32'hE3A0_1005 at addr 0:
  - imem_addr=0 in cycle 1;
  - instr_valid=1 in cycle 2 with cond=4'hE, op=2'b00, funct=6'b111010, rd=4'h1;
  - pc_plus8=8.
- Accept with pc_src=0 at pc=0 → next imem_addr=4. Accept with pc_src=1, result=32'h100 → next imem_addr=32'h100, align_err stays 0.
- imem_ready held low 5 cycles in FETCH → imem_req stays 1, instr_valid stays 0, capture on cycle 6. Then instr_accept low 3 cycles in ISSUE → instr and pc stable, imem_req=0.
- Accept with pc_src=1, result=32'h203 → imem_addr=32'h200 next cycle; align_err=1 for exactly one cycle.
- pc=32'hFFFF_FFFC, accept with pc_src=0 → pc=0; before accept, pc_plus8=32'h4.
- Reset asserted in the same cycle as imem_ready in FETCH → instr=0, instr_valid=0, pc=RESET_PC, fetch restarts at RESET_PC. Stray imem_ready in ISSUE → instr unchanged.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state, instruction field
// positions and the PC increments used for sequential fetch and R15 reads.
package instr_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  // MSB of each decoded field inside the 32-bit instruction word
  localparam int COND_MSB  = 31;
  localparam int OP_MSB    = 27;
  localparam int FUNCT_MSB = 25;
  localparam int RD_MSB    = 15;

  // Sequential fetch step and the architectural R15 read offset
  localparam int PC_INC     = 4;
  localparam int PC_R15_OFS = 8;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: sequential pc+4 or a word-aligned
// datapath target, plus the pc+8 value read as R15. Flags targets whose
// low two bits had to be dropped.
module instr_fetch_pc_next
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] result,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              misalign
);

  // Targets are forced to a word boundary; increments wrap naturally.
  always_comb begin
    next_pc  = pc_src ? {result[ADDR_W-1:2], 2'b00} : pc + ADDR_W'(PC_INC);
    pc_plus8 = pc + ADDR_W'(PC_R15_OFS);
    misalign = pc_src & (|result[1:0]);
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, reads one word per instruction from
// instruction memory, latches it in the instruction register and hands
// the decoded fields to control through a valid/accept handshake.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_accept,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] result,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              align_err
);

  fetch_state_e      state, state_n;
  logic              capture, accept_fire, misalign;
  logic [ADDR_W-1:0] next_pc;

  instr_fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc       (pc),
    .pc_src   (pc_src),
    .result   (result),
    .next_pc  (next_pc),
    .pc_plus8 (pc_plus8),
    .misalign (misalign)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Next state and handshake outputs; responses outside FETCH and
  // accepts outside ISSUE are simply not looked at.
  always_comb begin
    state_n     = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    accept_fire = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          capture = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_accept) begin
          accept_fire = 1'b1;
          state_n     = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // PC, instruction register and one-cycle misalignment pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr     <= 32'h0;
      align_err <= 1'b0;
    end else begin
      if (capture)     instr <= imem_rdata;
      if (accept_fire) pc    <= next_pc;
      align_err <= accept_fire & misalign;
    end
  end

  assign imem_addr = pc;

  // Fields come from the held instruction, never straight from memory
  assign cond  = instr[COND_MSB  -: 4];
  assign op    = instr[OP_MSB    -: 2];
  assign funct = instr[FUNCT_MSB -: 6];
  assign rd    = instr[RD_MSB    -: 4];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch. A driver plays instruction memory and
// control, keeps an architectural PC model and queues the instruction each
// fetched PC must deliver; a negedge monitor compares what the DUT shows.
module tb_instr_fetch;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CYCLES   = 5000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_accept;
  logic              pc_src;
  logic [ADDR_W-1:0] result;
  logic [31:0]       instr;
  logic [3:0]        cond;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [3:0]        rd;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus8;
  logic              align_err;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_accept(instr_accept),
    .pc_src(pc_src), .result(result),
    .instr(instr), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .pc(pc), .pc_plus8(pc_plus8), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Reference state
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic        exp_align = 1'b0;
  logic        chk_reset = 1'b0;
  logic        started   = 1'b0;
  logic        rst_pend  = 1'b0;
  logic        acc_pend  = 1'b0;
  logic        acc_src;
  logic [31:0] acc_res;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_hs      = 0;
  int          n_misal   = 0;

  // Memory image: an arbitrary but fixed word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1005;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc  = RESET_PC;
    exp_align = 1'b0;
    exp_q.push_back('{pc: RESET_PC, word: mem_word(RESET_PC)});
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFC;
      1: return 32'h0000_0203;
      2: return 32'h0000_0100;
      3: return 32'hFFFF_FFFF;
      4: return $urandom & 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  // Driver: memory responder, control stand-in and PC model
  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    instr_accept = 1'b0; pc_src = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_reset = 1'b1;
    reset     = 1'b0;
    started   = 1'b1;
    forever begin
      @(posedge clk); #1;
      // Apply what the previous cycle's inputs did at this edge
      if (rst_pend) begin
        model_reset();
        chk_reset = 1'b1;
      end else begin
        chk_reset = 1'b0;
        if (acc_pend) begin
          model_pc  = acc_src ? (acc_res & 32'hFFFF_FFFC) : model_pc + 32'd4;
          exp_align = acc_src && (acc_res % 4 != 0);
          exp_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
        end else begin
          exp_align = 1'b0;
        end
      end
      rst_pend = 1'b0; acc_pend = 1'b0; reset = 1'b0;
      // Next cycle's inputs
      instr_accept = 1'b0; imem_ready = 1'b0; imem_rdata = $urandom;
      pc_src = $urandom_range(0, 1); result = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1; rst_pend = 1'b1; imem_ready = 1'b1;
      end else if (imem_req) begin
        imem_ready   = ($urandom_range(0, 2) != 0);
        imem_rdata   = mem_word(imem_addr);
        instr_accept = ($urandom_range(0, 3) == 0);
      end else begin
        imem_ready = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) != 0) begin
          instr_accept = 1'b1;
          result       = pick_target();
          acc_pend     = 1'b1;
          acc_src      = pc_src;
          acc_res      = result;
          if (pc_src && result[1:0] != 2'b00) n_misal++;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin
    if (started) begin
      if (chk_reset) begin
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc", pc, RESET_PC);
      end
      chk("align_err", {31'b0, align_err}, {31'b0, exp_align});
      chk("req_xor_valid", {31'b0, imem_req ^ instr_valid}, 32'h1);
      if (imem_req) chk("imem_addr", imem_addr, model_pc);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL no_expect: instr %h valid with empty scoreboard at %0t", instr, $time);
        end else begin
          chk("instr", instr, exp_q[0].word);
          chk("pc", pc, exp_q[0].pc);
          if (instr_accept) begin
            chk("cond",  {28'b0, cond},  {28'b0, exp_q[0].word[31:28]});
            chk("op",    {30'b0, op},    {30'b0, exp_q[0].word[27:26]});
            chk("funct", {26'b0, funct}, {26'b0, exp_q[0].word[25:20]});
            chk("rd",    {28'b0, rd},    {28'b0, exp_q[0].word[15:12]});
            chk("pc_plus8", pc_plus8, exp_q[0].pc + 32'd8);
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end
    end
  end

  // Run length bound and summary
  initial begin
    repeat (CYCLES) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (n_hs >= 200) n_pass++;
    else $display("FAIL progress: handshakes %0d required >= 200", n_hs);
    n_checks++;
    if (n_misal >= 5) n_pass++;
    else $display("FAIL misalign_cov: misaligned accepts %0d required >= 5", n_misal);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
